// File: rtl/vector_alu_pipe_if.sv
// Handshake bundle between the register-file read stage, vector_alu_pipe and writeback.
// master = upstream issuer plus downstream consumer; slave = the ALU itself.
interface vector_alu_pipe_if #(
    parameter int LANES = 16
) ();
    localparam int W = 16 * LANES;

    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] op_1;
    logic [W-1:0] op_2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         err;

    modport master (
        output in_valid, opcode, op_1, op_2, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, opcode, op_1, op_2, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/vector_alu_pipe.sv
// Handshaked fp16 vector ALU: lane-wise VADD, scalar-by-vector SMUL and, when VALU_DOT_EN
// is defined, a sequential one-lane-per-cycle VDOT. Without VALU_DOT_EN, VDOT reports err.
module vector_alu_pipe #(
    parameter int LANES = 16
) (
    input  logic             clk,
    input  logic             rst,
    vector_alu_pipe_if.slave bus
);
    localparam int W = 16 * LANES;
    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    // Round-to-nearest-even and pack; subnormal results flush to signed zero, overflow to inf.
    function automatic logic [15:0] fp_pack(input logic s, input logic signed [7:0] e,
                                            input logic [10:0] m, input logic g, input logic st);
        logic [11:0]       mr;
        logic signed [7:0] er;
        logic [15:0]       r;
        er = e;
        mr = {1'b0, m} + {11'd0, (g & (st | m[0]))};
        if (mr[11]) begin
            mr = {1'b0, mr[11:1]};
            er = er + 8'sd1;
        end else begin
            mr = mr;
        end
        if (er >= 8'sd31) begin
            r = {s, 5'h1F, 10'h000};
        end else if (er <= 8'sd0) begin
            r = {s, 15'h0000};
        end else begin
            r = {s, er[4:0], mr[9:0]};
        end
        return r;
    endfunction

    function automatic logic [15:0] float_mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0]       prod;
        logic signed [7:0] e;
        logic [15:0]       r;
        if ((a[14:10] == 5'd0) || (b[14:10] == 5'd0)) begin
            r = {a[15] ^ b[15], 15'h0000};
        end else begin
            prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
            e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
            if (prod[21]) begin
                r = fp_pack(a[15] ^ b[15], e + 8'sd1, prod[21:11], prod[10], |prod[9:0]);
            end else begin
                r = fp_pack(a[15] ^ b[15], e, prod[20:10], prod[9], |prod[8:0]);
            end
        end
        return r;
    endfunction

    // A gap of 13+ exponents leaves the smaller operand below half an ulp, so the sum is exact in 28 bits otherwise.
    function automatic logic [15:0] float_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]       x, y, r;
        logic [4:0]        d, p;
        logic [26:0]       xw, yw;
        logic [27:0]       s, n;
        logic signed [7:0] e;
        p = 5'd0;
        if (a[14:10] == 5'd0) begin
            r = b;
        end else if (b[14:10] == 5'd0) begin
            r = a;
        end else begin
            if (a[14:0] >= b[14:0]) begin
                x = a;
                y = b;
            end else begin
                x = b;
                y = a;
            end
            d = x[14:10] - y[14:10];
            if (d >= 5'd13) begin
                r = x;
            end else begin
                xw = {1'b1, x[9:0], 16'h0000};
                yw = {1'b1, y[9:0], 16'h0000} >> d;
                if (x[15] == y[15]) begin
                    s = {1'b0, xw} + {1'b0, yw};
                end else begin
                    s = {1'b0, xw} - {1'b0, yw};
                end
                if (s == 28'd0) begin
                    r = 16'h0000;
                end else begin
                    for (int i = 0; i < 28; i++) begin
                        if (s[i]) p = 5'(i);
                    end
                    n = s << (5'd27 - p);
                    e = $signed({3'b000, x[14:10]}) + $signed({3'b000, p}) - 8'sd26;
                    r = fp_pack(x[15], e, n[27:17], n[16], |n[15:0]);
                end
            end
        end
        return r;
    endfunction

    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic         err_q;
    logic         in_ready_s;
    logic         accept_s;
    logic [W-1:0] single_res_d;
    logic         single_err_d;

    // Result of the single-cycle operation currently presented
    always_comb begin
        single_res_d = '0;
        single_err_d = 1'b0;
        case (bus.opcode)
            OP_VADD: begin
                for (int i = 0; i < LANES; i++) begin
                    single_res_d[16*i +: 16] = float_add(bus.op_1[16*i +: 16], bus.op_2[16*i +: 16]);
                end
            end
            OP_SMUL: begin
                for (int i = 0; i < LANES; i++) begin
                    single_res_d[16*i +: 16] = float_mul(bus.op_1[15:0], bus.op_2[16*i +: 16]);
                end
            end
            OP_NOP:  single_err_d = 1'b0;
`ifdef VALU_DOT_EN
            OP_VDOT: single_err_d = 1'b0;
`endif
            default: single_err_d = 1'b1;
        endcase
    end

`ifdef VALU_DOT_EN
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    typedef enum logic {IDLE = 1'b0, DOT = 1'b1} state_t;

    state_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]    acc_q;
    logic [15:0]    acc_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    // Next accumulator value for the lane selected by the counter
    always_comb begin
        acc_d = float_add(acc_q, float_mul(a_q[{cnt_q, 4'b0000} +: 16], b_q[{cnt_q, 4'b0000} +: 16]));
    end

    assign in_ready_s = (state_q == IDLE) && (!out_valid_q || bus.out_ready);

    // Issue, dot-product sequencing and the held output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= 16'h0000;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s && (bus.opcode == OP_VDOT)) begin
                        state_q     <= DOT;
                        cnt_q       <= '0;
                        acc_q       <= 16'h0000;
                        a_q         <= bus.op_1;
                        b_q         <= bus.op_2;
                        out_valid_q <= 1'b0;
                    end else if (accept_s) begin
                        result_q    <= single_res_d;
                        err_q       <= single_err_d;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= out_valid_q;
                    end
                end
                DOT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1'b1);
                    if (cnt_q == LAST_LANE) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        result_q    <= W'(acc_d);
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= DOT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign in_ready_s = !out_valid_q || bus.out_ready;

    // Output register: load on accept, clear when consumed, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else if (accept_s) begin
            result_q    <= single_res_d;
            err_q       <= single_err_d;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end
`endif

    assign accept_s      = bus.in_valid && in_ready_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe: directed table, multi-cycle corner sequences and a
// randomized scoreboard against a real-arithmetic fp16 model. Adapts to VALU_DOT_EN.
module tb_vector_alu_pipe;
    localparam int LANES = 16;
    localparam int W = 16 * LANES;
    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_alu_pipe_if #(.LANES(LANES)) bus_if ();
    vector_alu_pipe #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int checks = 0;
    int errors = 0;

    typedef struct { logic [W-1:0] res; logic err; } exp_t;
    typedef struct { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; logic err; } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) return 0.0;
        m = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -m : m;
    endfunction

    // Nearest fp16 to x, ties to even
    function automatic logic [15:0] r2h(input real x);
        real a, sc, fl, fr;
        int e, mi;
        if (x == 0.0) return 16'h0000;
        a = (x < 0.0) ? -x : x;
        e = 0;
        while (a >= pow2(e + 1)) e++;
        while (a < pow2(e)) e--;
        sc = a / pow2(e - 10);
        fl = $floor(sc);
        fr = sc - fl;
        mi = $rtoi(fl);
        if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        if (e + 15 >= 31) return {x < 0.0, 5'h1F, 10'h000};
        if (e + 15 <= 0) return {x < 0.0, 15'h0000};
        return {x < 0.0, 5'(e + 15), 10'(mi - 1024)};
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic [15:0] acc;
        r.res = '0;
        r.err = 1'b0;
        acc = 16'h0000;
        case (op)
            OP_VADD: for (int i = 0; i < LANES; i++) r.res[16*i +: 16] = r2h(h2r(a[16*i +: 16]) + h2r(b[16*i +: 16]));
            OP_SMUL: for (int i = 0; i < LANES; i++) r.res[16*i +: 16] = r2h(h2r(a[15:0]) * h2r(b[16*i +: 16]));
            OP_NOP:  r.err = 1'b0;
            OP_VDOT: begin
`ifdef VALU_DOT_EN
                for (int i = 0; i < LANES; i++) acc = r2h(h2r(acc) + h2r(r2h(h2r(a[16*i +: 16]) * h2r(b[16*i +: 16]))));
                r.res[15:0] = acc;
`else
                r.err = 1'b1;
`endif
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] rand_h(input bit pos_only, input int emin, input int emax);
        return {pos_only ? 1'b0 : 1'($urandom), 5'($urandom_range(emax, emin)), 10'($urandom)};
    endfunction

    function automatic logic [W-1:0] rand_vec(input bit pos_only, input int emin, input int emax);
        logic [W-1:0] v;
        for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_h(pos_only, emin, emax);
        return v;
    endfunction

    function automatic logic [W-1:0] splat(input logic [15:0] h);
        return {LANES{h}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus_if.in_valid = 1'b1;
        bus_if.opcode   = op;
        bus_if.op_1     = a;
        bus_if.op_2     = b;
    endtask

    // Present an op, wait (bounded) for in_ready, return 1 time unit after the accept edge
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        drive(op, a, b);
        #1;
        while (!bus_if.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_timeout", W'(n), W'(0));
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tbl[6];
    exp_t q[$];
    exp_t ex;
    logic [W-1:0] va, vb, held;
    int lat, stale, sent, cyc;
    logic hs_in, hs_out, act_err;
    logic [W-1:0] act_res;

    initial begin
        va = rand_vec(1'b0, 0, 31);
        va[15:0] = 16'h4000;
        tbl[0] = '{OP_VADD, splat(16'h3C00), splat(16'hBC00), '0, 1'b0};
        tbl[1] = '{OP_SMUL, va, splat(16'h4200), splat(16'h4600), 1'b0};
        tbl[2] = '{OP_VADD, splat(16'h3C00), splat(16'h3C00), splat(16'h4000), 1'b0};
        tbl[3] = '{OP_NOP, splat(16'h4400), splat(16'h4400), '0, 1'b0};
        tbl[4] = '{4'b1000, splat(16'h3C00), splat(16'h3C00), '0, 1'b1};
        tbl[5] = '{4'b0111, splat(16'h4000), splat(16'h4000), '0, 1'b1};

        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.opcode    = OP_NOP;
        bus_if.op_1      = '0;
        bus_if.op_2      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", W'(bus_if.out_valid), W'(0));
        chk("reset_result", bus_if.result, '0);
        chk("reset_err", W'(bus_if.err), W'(0));
        chk("reset_in_ready", W'(bus_if.in_ready), W'(1));

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_out_valid", i), W'(bus_if.out_valid), W'(1));
            chk($sformatf("tbl%0d_result", i), bus_if.result, tbl[i].res);
            chk($sformatf("tbl%0d_err", i), W'(bus_if.err), W'(tbl[i].err));
        end

        // Backpressure: hold a result for 5 cycles while the next VADD waits upstream
        tick();
        bus_if.out_ready = 1'b0;
        send(OP_VADD, splat(16'h3C00), splat(16'h3C00));
        va = rand_vec(1'b0, 14, 20);
        vb = rand_vec(1'b0, 14, 20);
        drive(OP_VADD, va, vb);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_valid", W'(bus_if.out_valid), W'(1));
            chk("bp_result_held", bus_if.result, splat(16'h4000));
            chk("bp_in_ready", W'(bus_if.in_ready), W'(0));
            tick();
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", W'(bus_if.in_ready), W'(1));
        tick();
        bus_if.in_valid = 1'b0;
        ex = model(OP_VADD, va, vb);
        chk("bp_new_valid", W'(bus_if.out_valid), W'(1));
        chk("bp_new_result", bus_if.result, ex.res);

        // VDOT: latency, in_ready low while busy, then held under backpressure
        tick();
        send(OP_VDOT, splat(16'h3C00), splat(16'h4000));
        bus_if.out_ready = 1'b0;
`ifdef VALU_DOT_EN
        lat = 1;
        while (!bus_if.out_valid && lat < 64) begin
            chk("dot_in_ready_busy", W'(bus_if.in_ready), W'(0));
            tick();
            lat++;
        end
        chk("dot_latency", W'(lat), W'(LANES));
        chk("dot_result", bus_if.result, W'(16'h5000));
        chk("dot_err", W'(bus_if.err), W'(0));
        repeat (3) begin
            tick();
            chk("dot_held_valid", W'(bus_if.out_valid), W'(1));
            chk("dot_held_in_ready", W'(bus_if.in_ready), W'(0));
            chk("dot_held_result", bus_if.result, W'(16'h5000));
        end
`else
        chk("vdot_off_valid", W'(bus_if.out_valid), W'(1));
        chk("vdot_off_result", bus_if.result, '0);
        chk("vdot_off_err", W'(bus_if.err), W'(1));
`endif
        bus_if.out_ready = 1'b1;
        tick();
        chk("drain_out_valid", W'(bus_if.out_valid), W'(0));

        // Reset while work is in flight: mid-VDOT, or a held result without the dot unit
`ifdef VALU_DOT_EN
        send(OP_VDOT, rand_vec(1'b1, 14, 18), rand_vec(1'b1, 14, 18));
        repeat (4) tick();
`else
        bus_if.out_ready = 1'b0;
        send(OP_VADD, splat(16'h3C00), splat(16'h3C00));
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        #1;
        chk("rst_mid_out_valid", W'(bus_if.out_valid), W'(0));
        chk("rst_mid_in_ready", W'(bus_if.in_ready), W'(1));
        stale = 0;
        repeat (LANES + 2) begin
            if (bus_if.out_valid) stale++;
            tick();
        end
        chk("rst_no_stale", W'(stale), W'(0));
        va = rand_vec(1'b0, 14, 20);
        vb = rand_vec(1'b0, 14, 20);
        send(OP_VADD, va, vb);
        ex = model(OP_VADD, va, vb);
        chk("rst_after_vadd", bus_if.result, ex.res);
        tick();

        // Randomized traffic against the scoreboard
        sent = 0;
        cyc = 0;
        while ((sent < 150 || q.size() > 0 || bus_if.in_valid) && cyc < 20000) begin
            if (!bus_if.in_valid && sent < 150 && $urandom_range(3, 0) != 0) begin
                case ($urandom_range(7, 0))
                    0, 1, 2: drive(OP_VADD, rand_vec(1'b0, 14, 20), rand_vec(1'b0, 14, 20));
                    3, 4:    drive(OP_SMUL, rand_vec(1'b0, 14, 20), rand_vec(1'b0, 14, 20));
                    5:       drive(OP_NOP, rand_vec(1'b0, 0, 31), rand_vec(1'b0, 0, 31));
                    6:       drive(OP_VDOT, rand_vec(1'b1, 14, 18), rand_vec(1'b1, 14, 18));
                    default: drive(4'($urandom_range(14, 3)), rand_vec(1'b0, 0, 31), rand_vec(1'b0, 0, 31));
                endcase
            end
            bus_if.out_ready = ($urandom_range(3, 0) != 0);
            #1;
            hs_in   = bus_if.in_valid && bus_if.in_ready;
            hs_out  = bus_if.out_valid && bus_if.out_ready;
            act_res = bus_if.result;
            act_err = bus_if.err;
            @(posedge clk);
            if (hs_out) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_output", W'(1), W'(0));
                end else begin
                    ex = q.pop_front();
                    chk("rand_result", act_res, ex.res);
                    chk("rand_err", W'(act_err), W'(ex.err));
                end
            end
            if (hs_in) begin
                q.push_back(model(bus_if.opcode, bus_if.op_1, bus_if.op_2));
                sent++;
            end
            #1;
            if (hs_in) bus_if.in_valid = 1'b0;
            cyc++;
        end
        chk("rand_completed", W'(cyc < 20000), W'(1));
        chk("rand_scoreboard_empty", W'(q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_alu_pipe.md
# vector_alu_pipe

Parametrised, handshaked successor to the single-cycle vector ALU. Executes half-precision (fp16) vector operations on LANES-wide operands: lane-wise add, scalar-by-vector multiply, and a multi-cycle dot product with a sequential accumulator. It sits between the register-file read stage and writeback, and uses valid/ready on both sides so that a long VDOT can stall issue.

## Interface
- LANES, 16: number of fp16 lanes; data width W = 16*LANES; LANES ≥ 1.
- CNT_W, $clog2(LANES) (min 1): derived width of the lane counter; not overridden.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts an operation this cycle.
- opcode  in  4  VADD=4'b0000, VDOT=4'b0001, SMUL=4'b0010, NOP=4'b1111; all others are unsupported here.
- op_1  in  W  operand 1; lane i = bits [16*i +: 16].
- op_2  in  W  operand 2; same lane layout.
- out_valid  out  1  result held for downstream.
- out_ready  in  1  downstream consumes result.
- result  out  W  result vector.
- err  out  1  result belongs to an unsupported opcode; qualified by out_valid.

## Operation
- Accept occurs on a rising edge where in_valid && in_ready; opcode and operands are captured at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- VADD: result lane i = float_add(op_1[i], op_2[i]), using the shared functions.v helpers.
- SMUL: result lane i = float_mul(op_1[15:0], op_2[i]); the scalar is lane 0 of op_1.
- VDOT: acc starts at 16'h0000. For i = 0..LANES-1 in order, acc = float_add(acc, float_mul(a[i], b[i])), one lane per cycle. result = {W-16 zero bits, acc}.
- NOP: result all-zero, err=0.
- Unsupported opcode: result all-zero, err=1, same latency as VADD.
- FSM:
  - IDLE: accept VADD/SMUL/NOP/unsupported → write result, out_valid=1, stay in IDLE. Accept VDOT → DOT, cnt=0, acc=0.
  - DOT: accumulate lane cnt; cnt++; if cnt==LANES-1 → write result, out_valid=1, go to IDLE.
- Output register: once out_valid=1, result, err and out_valid hold stable until a cycle with out_ready=1. On that edge out_valid clears, unless a new single-cycle op is accepted on the same edge, in which case the new result loads (back-to-back issue at full rate).

## Timing
- Reset values: out_valid=0, result=0, err=0, state=IDLE, cnt=0, acc=0. in_ready=1 in the cycle after reset deasserts.
- rst has priority over all activity. Asserting it mid-VDOT or while a result is held discards all work; no stale result appears afterwards.
- VADD/SMUL/NOP/unsupported: out_valid rises 1 cycle after the accept edge.
- VDOT: out_valid rises LANES cycles after the accept edge (16 with default). in_ready=0 throughout DOT.
- If out_ready=0 when VDOT finishes: result holds and in_ready stays 0 until it is consumed.
- in_valid while in_ready=0 is ignored; the upstream holds its request.
- Throughput: 1 op/cycle for single-cycle ops when out_ready=1; VDOT is not pipelined.

## Configuration
- VALU_DOT_EN defined: VDOT, the DOT state, the counter and the accumulator are compiled in.
- VALU_DOT_EN undefined: VDOT is treated as an unsupported opcode (zero result, err=1, 1-cycle latency). No DOT state or accumulator logic is present.

## Test plan
- VADD, all lanes op_1=16'h3C00, op_2=16'hBC00, out_ready=1 → 1 cycle later out_valid=1, every lane 16'h0000, err=0.
- SMUL, op_1[15:0]=16'h4000, all op_2 lanes 16'h4200 → every lane 16'h4600; upper op_1 lanes ignored (randomise them).
- VDOT (macro on, LANES=16), all op_1 lanes 16'h3C00, op_2 lanes 16'h4000 → exactly 16 cycles after accept, result[15:0]=16'h5000, upper bits 0; in_ready=0 for those cycles.
- Backpressure: VADD result with out_ready=0 for 5 cycles → result/out_valid stable, in_ready=0. Then out_ready=1 with a new VADD presented → the new result loads on the same edge.
- Reset mid-VDOT: rst high at cycle 5 of DOT → next cycle out_valid=0, state IDLE, in_ready=1. A following VADD returns a correct result.
- opcode 4'b1000 → out_valid with result=0, err=1. Rebuilt without VALU_DOT_EN, VDOT → err=1 after 1 cycle.
